// File: rtl/gp_cmd_fetcher.sv
`default_nettype none
// ============================================================================
// Module      : gp_cmd_fetcher
// Description : Graphics-processor command-list reader. Once the CPU writes
//               the code pointer, it fetches command words one at a time,
//               decodes FILL / LINE / STOP and hands each command to the fill
//               or line engine over a valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module gp_cmd_fetcher #(
  parameter int ADDR_W  = 30,
  parameter int COORD_W = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        gp_code_addr,
  input  logic               gp_code_we,
  input  logic [31:0]        gp_frame_addr,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic               mem_req,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic               mem_ready,
  input  logic               mem_rvalid,
  input  logic [31:0]        mem_rdata,
  output logic [31:0]        frame_base,
  output logic               fill_valid,
  input  logic               fill_ready,
  output logic [23:0]        fill_color,
  output logic               line_valid,
  input  logic               line_ready,
  output logic [23:0]        line_color,
  output logic [COORD_W-1:0] line_x0,
  output logic [COORD_W-1:0] line_y0,
  output logic [COORD_W-1:0] line_x1,
  output logic [COORD_W-1:0] line_y1
);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_REQ        = 3'd1,
    S_WAIT       = 3'd2,
    S_DECODE     = 3'd3,
    S_ARG_REQ    = 3'd4,
    S_ARG_WAIT   = 3'd5,
    S_ISSUE_FILL = 3'd6,
    S_ISSUE_LINE = 3'd7
  } state_t;

  localparam logic [7:0]        c_OP_STOP  = 8'h00;
  localparam logic [7:0]        c_OP_FILL  = 8'h01;
  localparam logic [7:0]        c_OP_LINE  = 8'h02;
  localparam logic [ADDR_W-1:0] c_PTR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t              r_state;
  logic [ADDR_W-1:0]   r_ptr;         // word address of the next fetch
  logic [31:0]         r_word;        // header word under decode
  logic                r_arg_second;  // next LINE argument is the x1/y1 word

  // Byte-offset bits of the code pointer carry no meaning for word fetches.
  logic w_unused;
  assign w_unused = ^gp_code_addr[1:0];

  // Fetch/decode/issue sequencer; every output is a register written here.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_ptr        <= '0;
      r_word       <= '0;
      r_arg_second <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      mem_req      <= 1'b0;
      mem_addr     <= '0;
      frame_base   <= '0;
      fill_valid   <= 1'b0;
      fill_color   <= '0;
      line_valid   <= 1'b0;
      line_color   <= '0;
      line_x0      <= '0;
      line_y0      <= '0;
      line_x1      <= '0;
      line_y1      <= '0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (gp_code_we) begin
            r_ptr      <= gp_code_addr[ADDR_W+1:2];
            mem_addr   <= gp_code_addr[ADDR_W+1:2];
            frame_base <= gp_frame_addr;
            err        <= 1'b0;
            busy       <= 1'b1;
            mem_req    <= 1'b1;
            r_state    <= S_REQ;
          end
        end

        S_REQ, S_ARG_REQ: begin
          if (mem_ready) begin
            mem_req <= 1'b0;
            r_ptr   <= r_ptr + c_PTR_ONE;
            r_state <= (r_state == S_REQ) ? S_WAIT : S_ARG_WAIT;
          end
        end

        // Terminal opcodes are recognised at capture so that done/busy/err
        // are already registered during the DECODE cycle itself.
        S_WAIT: begin
          if (mem_rvalid) begin
            r_word  <= mem_rdata;
            r_state <= S_DECODE;
            if (mem_rdata[31:24] == c_OP_STOP) begin
              done <= 1'b1;
              busy <= 1'b0;
            end else if (mem_rdata[31:24] != c_OP_FILL &&
                         mem_rdata[31:24] != c_OP_LINE) begin
              err  <= 1'b1;
              busy <= 1'b0;
            end
          end
        end

        S_DECODE: begin
          case (r_word[31:24])
            c_OP_FILL: begin
              fill_color <= r_word[23:0];
              fill_valid <= 1'b1;
              r_state    <= S_ISSUE_FILL;
            end
            c_OP_LINE: begin
              line_color   <= r_word[23:0];
              r_arg_second <= 1'b0;
              mem_req      <= 1'b1;
              mem_addr     <= r_ptr;
              r_state      <= S_ARG_REQ;
            end
            default: r_state <= S_IDLE;
          endcase
        end

        S_ARG_WAIT: begin
          if (mem_rvalid) begin
            if (!r_arg_second) begin
              line_x0      <= mem_rdata[16 +: COORD_W];
              line_y0      <= mem_rdata[0 +: COORD_W];
              r_arg_second <= 1'b1;
              mem_req      <= 1'b1;
              mem_addr     <= r_ptr;
              r_state      <= S_ARG_REQ;
            end else begin
              line_x1    <= mem_rdata[16 +: COORD_W];
              line_y1    <= mem_rdata[0 +: COORD_W];
              line_valid <= 1'b1;
              r_state    <= S_ISSUE_LINE;
            end
          end
        end

        S_ISSUE_FILL: begin
          if (fill_ready) begin
            fill_valid <= 1'b0;
            mem_req    <= 1'b1;
            mem_addr   <= r_ptr;
            r_state    <= S_REQ;
          end
        end

        S_ISSUE_LINE: begin
          if (line_ready) begin
            line_valid <= 1'b0;
            mem_req    <= 1'b1;
            mem_addr   <= r_ptr;
            r_state    <= S_REQ;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_gp_cmd_fetcher.sv
`default_nettype none
// ============================================================================
// Module      : tb_gp_cmd_fetcher
// Description : Directed self-checking bench for gp_cmd_fetcher.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_gp_cmd_fetcher;
  localparam int ADDR_W  = 30;
  localparam int COORD_W = 10;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic [31:0]        gp_code_addr = '0;
  logic               gp_code_we = 1'b0;
  logic [31:0]        gp_frame_addr = '0;
  logic               busy, done, err, mem_req;
  logic [ADDR_W-1:0]  mem_addr;
  logic               mem_ready = 1'b0;
  logic               mem_rvalid = 1'b0;
  logic [31:0]        mem_rdata = '0;
  logic [31:0]        frame_base;
  logic               fill_valid;
  logic               fill_ready = 1'b0;
  logic [23:0]        fill_color;
  logic               line_valid;
  logic               line_ready = 1'b0;
  logic [23:0]        line_color;
  logic [COORD_W-1:0] line_x0, line_y0, line_x1, line_y1;

  gp_cmd_fetcher #(.ADDR_W(ADDR_W), .COORD_W(COORD_W)) dut (
    .clk(clk), .rst(rst),
    .gp_code_addr(gp_code_addr), .gp_code_we(gp_code_we), .gp_frame_addr(gp_frame_addr),
    .busy(busy), .done(done), .err(err),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ready(mem_ready),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .frame_base(frame_base),
    .fill_valid(fill_valid), .fill_ready(fill_ready), .fill_color(fill_color),
    .line_valid(line_valid), .line_ready(line_ready), .line_color(line_color),
    .line_x0(line_x0), .line_y0(line_y0), .line_x1(line_x1), .line_y1(line_y1)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // environment knobs
  logic [31:0] img [16];
  logic [29:0] img_base = '0;
  int  stall_n  = 0;
  bit  rand_rdy = 0;
  bit  rand_lat = 0;
  bit  force_rv = 0;

  // observation log
  logic [23:0] fill_q [$];
  logic [63:0] line_q [$];
  logic [29:0] rd_q   [$];
  int  done_cnt = 0;
  int  viol     = 0;
  int  cyc      = 0;
  int  first_rv = -1;
  int  first_fv = -1;

  // memory responder / engine readies / protocol monitor
  bit          pend = 0;
  int          dly  = 0;
  logic [29:0] pend_addr = '0;
  int          fwait = 0, lwait = 0;
  bit          p_fv = 0, p_fr = 0, p_lv = 0, p_lr = 0, p_mr = 0, p_mrdy = 0;
  logic [23:0] p_fc = '0;
  logic [63:0] p_line = '0;
  logic [29:0] p_ma = '0;

  function automatic logic [31:0] fetch(input logic [29:0] a);
    logic [29:0] off;
    off = a - img_base;
    return (off < 30'd16) ? img[off[3:0]] : 32'h0;
  endfunction

  always @(negedge clk) begin
    cyc++;
    mem_rvalid = 1'b0;
    if (!rst) begin
      pend = 0; fwait = 0; lwait = 0;
      p_fv = 0; p_lv = 0; p_mr = 0;
    end
    if (force_rv) begin
      mem_rvalid = 1'b1;
      mem_rdata  = 32'h01000000;
    end else if (pend) begin
      if (dly == 0) begin
        mem_rvalid = 1'b1;
        mem_rdata  = fetch(pend_addr);
        pend       = 0;
        if (first_rv < 0) first_rv = cyc;
      end else dly--;
    end
    mem_ready  = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    fwait      = fill_valid ? fwait + 1 : 0;
    lwait      = line_valid ? lwait + 1 : 0;
    fill_ready = (fwait > stall_n);
    line_ready = (lwait > stall_n);
    if (rst) begin
      if (mem_req && mem_ready) begin
        rd_q.push_back(mem_addr);
        pend = 1; pend_addr = mem_addr;
        dly  = rand_lat ? int'($urandom_range(0, 3)) : 0;
      end
      if (fill_valid && fill_ready) fill_q.push_back(fill_color);
      if (line_valid && line_ready)
        line_q.push_back({line_color, line_x0, line_y0, line_x1, line_y1});
      if (done) begin done_cnt++; if (busy) viol++; end
      if (fill_valid && line_valid) viol++;
      if (mem_req && (fill_valid || line_valid)) viol++;
      if (p_fv && !p_fr && !(fill_valid && fill_color == p_fc)) viol++;
      if (p_lv && !p_lr && !(line_valid &&
          {line_color, line_x0, line_y0, line_x1, line_y1} == p_line)) viol++;
      if (p_mr && !p_mrdy && !(mem_req && mem_addr == p_ma)) viol++;
      if (fill_valid && first_fv < 0) first_fv = cyc;
      p_fv = fill_valid; p_fr = fill_ready; p_fc = fill_color;
      p_lv = line_valid; p_lr = line_ready;
      p_line = {line_color, line_x0, line_y0, line_x1, line_y1};
      p_mr = mem_req; p_mrdy = mem_ready; p_ma = mem_addr;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    fill_q.delete(); line_q.delete(); rd_q.delete();
    done_cnt = 0; viol = 0; first_rv = -1; first_fv = -1;
  endtask

  task automatic load_list1(input logic [29:0] base);
    img_base = base;
    for (int i = 0; i < 16; i++) img[i] = 32'h0;
    img[0] = 32'h01000000; img[1] = 32'h020000ff; img[2] = 32'h00100020;
    img[3] = 32'h001a002b; img[4] = 32'h02ff0000; img[5] = 32'h01230124;
    img[6] = 32'h00aa00bb; img[7] = 32'h00000000;
  endtask

  task automatic start(input logic [31:0] a, input logic [31:0] f);
    @(negedge clk); #1;
    gp_code_addr = a; gp_frame_addr = f; gp_code_we = 1'b1;
    @(negedge clk); #1;
    gp_code_we = 1'b0;
  endtask

  task automatic run_to_idle(input string tag, input int budget);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    checks++;
    assert (n < budget) else begin
      errors++;
      $error("FAIL %s timeout: waited %0d cycles, required fewer than %0d", tag, n, budget);
    end
    repeat (3) @(negedge clk);
    #1;
  endtask

  logic [63:0] exp_line [2];

  task automatic check_seq(input string tag, input logic [29:0] base);
    chk($sformatf("%s fill count", tag), 64'(fill_q.size()), 64'd1);
    if (fill_q.size() > 0) chk($sformatf("%s fill color", tag), 64'(fill_q[0]), 64'h0);
    chk($sformatf("%s line count", tag), 64'(line_q.size()), 64'd2);
    for (int i = 0; i < 2; i++)
      if (i < line_q.size()) chk($sformatf("%s line%0d", tag, i), line_q[i], exp_line[i]);
    chk($sformatf("%s done count", tag), 64'(done_cnt), 64'd1);
    chk($sformatf("%s read count", tag), 64'(rd_q.size()), 64'd8);
    for (int i = 0; i < 8; i++)
      if (i < rd_q.size()) chk($sformatf("%s read%0d addr", tag, i), 64'(rd_q[i]), 64'(base + 30'(i)));
    chk($sformatf("%s protocol violations", tag), 64'(viol), 64'd0);
    chk($sformatf("%s err", tag), 64'(err), 64'd0);
  endtask

  localparam logic [29:0] BASE1 = 30'h05E00000;

  initial begin
    int n;
    exp_line[0] = {24'h0000ff, 10'd16, 10'd32, 10'd26, 10'd43};
    exp_line[1] = {24'hff0000, 10'd291, 10'd292, 10'd170, 10'd187};

    // reset values
    repeat (3) @(negedge clk);
    #1;
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset mem_req", 64'(mem_req), 64'd0);
    chk("reset valids", 64'({fill_valid, line_valid, done, err}), 64'd0);
    chk("reset mem_addr", 64'(mem_addr), 64'd0);
    chk("reset frame_base", 64'(frame_base), 64'd0);
    #1 rst = 1'b1;

    // scenario 1: zero latency, ready high
    load_list1(BASE1); clear_log();
    start(32'h17800000, 32'h20000000);
    chk("s1 mem_req after start", 64'(mem_req), 64'd1);
    chk("s1 mem_addr after start", 64'(mem_addr), 64'(BASE1));
    chk("s1 busy after start", 64'(busy), 64'd1);
    chk("s1 frame_base", 64'(frame_base), 64'h20000000);
    run_to_idle("s1", 400);
    check_seq("s1", BASE1);
    chk("s1 fill_valid latency", 64'(first_fv - first_rv), 64'd2);

    // scenario 2: engines stall 5 cycles
    stall_n = 5; clear_log();
    start(32'h17800000, 32'h20000000);
    run_to_idle("s2", 400);
    check_seq("s2", BASE1);

    // scenario 3: random mem_ready, 1-4 cycle read latency
    stall_n = 0; rand_rdy = 1; rand_lat = 1; clear_log();
    start(32'h17800000, 32'h20000000);
    run_to_idle("s3", 1000);
    check_seq("s3", BASE1);
    rand_rdy = 0; rand_lat = 0;

    // scenario 4: unknown opcode, then recovery
    img_base = 30'h400;
    for (int i = 0; i < 16; i++) img[i] = 32'h0;
    img[0] = 32'h7f000000;
    clear_log();
    start(32'h00001000, 32'h30000000);
    run_to_idle("s4", 200);
    chk("s4 err", 64'(err), 64'd1);
    chk("s4 busy", 64'(busy), 64'd0);
    chk("s4 engine commands", 64'(fill_q.size() + line_q.size()), 64'd0);
    chk("s4 done count", 64'(done_cnt), 64'd0);
    chk("s4 read count", 64'(rd_q.size()), 64'd1);
    load_list1(BASE1); clear_log();
    start(32'h17800000, 32'h20000000);
    chk("s4 err cleared by start", 64'(err), 64'd0);
    run_to_idle("s4b", 400);
    check_seq("s4b", BASE1);

    // scenario 5: start pulse while busy is ignored
    stall_n = 5; clear_log();
    start(32'h17800000, 32'h20000000);
    repeat (4) @(negedge clk);
    #1;
    chk("s5 busy before extra start", 64'(busy), 64'd1);
    gp_code_addr = 32'h10000000; gp_frame_addr = 32'h44444444; gp_code_we = 1'b1;
    @(negedge clk); #1;
    gp_code_we = 1'b0;
    run_to_idle("s5", 400);
    check_seq("s5", BASE1);
    chk("s5 frame_base kept", 64'(frame_base), 64'h20000000);

    // scenario 6: reset during ISSUE_LINE with a stray mem_rvalid
    clear_log();
    start(32'h17800000, 32'h20000000);
    n = 0;
    while (line_valid !== 1'b1 && n < 200) begin
      @(negedge clk); #1;
      n++;
    end
    chk("s6 reached line issue", 64'(line_valid), 64'd1);
    force_rv = 1;
    rst = 1'b0;
    #1;
    chk("s6 rst busy/req/valids", 64'({busy, done, err, mem_req, fill_valid, line_valid}), 64'd0);
    chk("s6 rst mem_addr", 64'(mem_addr), 64'd0);
    chk("s6 rst frame_base", 64'(frame_base), 64'd0);
    chk("s6 rst colors", 64'({fill_color, line_color}), 64'd0);
    chk("s6 rst coords", 64'({line_x0, line_y0, line_x1, line_y1}), 64'd0);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      chk($sformatf("s6 idle after release %0d", i),
          64'({busy, mem_req, fill_valid, line_valid}), 64'd0);
    end
    force_rv = 0;
    stall_n = 0;
    repeat (2) @(negedge clk);
    clear_log();
    start(32'h17800000, 32'h20000000);
    run_to_idle("s6", 400);
    check_seq("s6", BASE1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // global time limit
  initial begin
    #500000;
    errors++;
    $display("FAIL global timeout: simulation still running at %0t", $time);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/gp_cmd_fetcher.md
# gp_cmd_fetcher

Command-list reader for the graphics processor. It runs once the CPU writes the GP code pointer (0x18000000), reads the command list word by word from memory starting at that pointer, and decodes fill and line commands. Each decoded command goes to the fill engine or the line engine over a valid/ready handshake, together with the frame-buffer base the CPU wrote to 0x18000004. It stops at a zero (STOP) word or at an unknown opcode.

## Interface
- ADDR_W, 30: word-address width of the memory read port.
- COORD_W, 10: coordinate width delivered to the line engine (low bits of each 16-bit field).

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-low reset.
- gp_code_addr  in  32  byte address of command list; bits [1:0] ignored.
- gp_code_we  in  1  one-cycle pulse: CPU wrote the code pointer (start).
- gp_frame_addr  in  32  frame-buffer base; latched on accepted start.
- busy  out  1  high from accepted start until STOP/error retires.
- done  out  1  one-cycle pulse when STOP word decoded.
- err  out  1  set on unknown opcode; cleared by next accepted start.
- mem_req  out  1  read request.
- mem_addr  out  ADDR_W  word address of request.
- mem_ready  in  1  request accepted when mem_req && mem_ready.
- mem_rvalid  in  1  read data valid.
- mem_rdata  in  32  read data.
- frame_base  out  32  latched gp_frame_addr, stable while busy.
- fill_valid  out  1  fill command pending.
- fill_ready  in  1  fill engine accepts.
- fill_color  out  24  fill colour.
- line_valid  out  1  line command pending.
- line_ready  in  1  line engine accepts.
- line_color  out  24  line colour.
- line_x0, line_y0, line_x1, line_y1  out  COORD_W each  endpoints.

## Operation
- Command word: opcode = [31:24], colour = [23:0]. 0x00 = STOP, 0x01 = FILL (1 word), 0x02 = LINE (3 words: header, then x0/y0, then x1/y1). In argument words x = [31:16] and y = [15:0]; the low COORD_W bits of each are kept.
- States: IDLE, REQ, WAIT, DECODE, ARG_REQ, ARG_WAIT, ISSUE_FILL, ISSUE_LINE.
- IDLE: on gp_code_we, latch ptr = gp_code_addr[31:2] and frame_base, clear err, set busy, go to REQ. gp_code_we while busy is ignored.
- REQ/ARG_REQ: drive mem_req = 1 and mem_addr = ptr. On mem_ready, ptr increments (mod 2^30, wraps silently) and the FSM goes to WAIT/ARG_WAIT.
- WAIT: on mem_rvalid, capture mem_rdata and go to DECODE. mem_rvalid is ignored in every non-wait state.
- DECODE:
  - STOP: pulse done, clear busy, go to IDLE.
  - FILL: go to ISSUE_FILL.
  - LINE: arg count = 2, go to ARG_REQ.
  - Other opcode: set err, clear busy, go to IDLE.
- ARG_WAIT: on mem_rvalid, store the first argument to x0/y0 and the second to x1/y1. Return to ARG_REQ until both are stored, then go to ISSUE_LINE.
- ISSUE_*: hold valid and all payload outputs stable until ready. In the valid&&ready cycle, go to REQ.
- Only one memory read is outstanding at a time. fill_valid and line_valid are never high together.

## Timing
- Reset values: busy, done, err, mem_req, fill_valid, line_valid = 0. mem_addr, frame_base, colours and coordinates = 0. FSM = IDLE.
- Reset asserted mid-operation aborts immediately; any late mem_rvalid is ignored.
- mem_req is high in the cycle after the accepted gp_code_we.
- mem_req, once high, stays high with a constant mem_addr until mem_ready.
- DECODE takes exactly one cycle after the mem_rvalid capture.
- fill_valid rises 2 cycles after the header's mem_rvalid.
- The next mem_req rises in the cycle after the command's valid&&ready.
- done pulses in the DECODE cycle of STOP; busy falls in the same cycle.
- mem_rvalid in the same cycle as mem_ready is illegal; data arrives at least 1 cycle after acceptance.

## Test plan
- Zero-latency memory, ready tied high: start at 0x17800000 with list 0x01000000, 0x020000ff, 0x00100020, 0x001a002b, 0x02ff0000, 0x01230124, 0x00aa00bb, 0x00000000. Required: fill color 0x000000; then line color 0x0000ff (16,32)->(26,43); then line color 0xff0000 (291,292)->(170,187); then done; 8 reads at word addresses 0x05E00000 through 0x05E00007.
- Same list with fill_ready/line_ready low for 5 cycles each: valid and payload held stable, no extra mem_req during the stall, same command sequence.
- mem_ready random and mem_rvalid delayed 1–4 cycles: mem_addr stable while mem_req is high, sequence identical to the first scenario.
- List 0x7f000000: err = 1, busy = 0, no engine valid. A following start clears err and runs normally.
- gp_code_we pulsed while busy with a different address: ignored, original list completes.
- rst low during ISSUE_LINE with a pending mem_rvalid: all outputs 0 immediately. After release, the FSM stays IDLE until the next gp_code_we.
